// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared types, widths and timing defaults
// for the RTC parallel bus arbiter.
package rtc_bus_pkg;

  localparam int RTC_ADDR_W  = 8;
  localparam int RTC_DATA_W  = 8;
  localparam int T_PULSE_DEF = 7;
  localparam int T_GAP_DEF   = 7;
  localparam int CNT_W       = $clog2(32);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_ACT,
    ADDR_GAP,
    DATA_ACT,
    DATA_GAP
  } state_e;

  // Phase counters count down to zero; load with length-1.
  function automatic logic [CNT_W-1:0] phase_last(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_rr_arbiter.sv
// rtc_rr_arbiter: combinational round-robin pick, searching
// cyclically from ptr_i; returns one-hot grant and its index.
module rtc_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int k;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin owner of the multiplexed RTC bus.
// Define RTC_BUS_LOCK_EN to let a locked requester keep the bus.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_wr,
  input  logic [RTC_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [RTC_DATA_W*N_REQ-1:0] req_wdata,
  input  logic [N_REQ-1:0]            req_lock,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic [RTC_DATA_W-1:0]       rdata,
  output logic [RTC_DATA_W-1:0]       ad_out,
  output logic                        ad_oe,
  input  logic [RTC_DATA_W-1:0]       ad_in,
  output logic                        AD_o,
  output logic                        CS,
  output logic                        RD,
  output logic                        WR
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] P_LAST = phase_last(T_PULSE);
  localparam logic [CNT_W-1:0] G_LAST = phase_last(T_GAP);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      done_q, done_d;
  logic                  wr_q, wr_d;
  logic                  oe_q, oe_d;
  logic                  lock_q, lock_d;
  logic [RTC_DATA_W-1:0] wdata_q, wdata_d;
  logic [RTC_DATA_W-1:0] ad_q, ad_d;
  logic [RTC_DATA_W-1:0] rdata_q, rdata_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    g_idx;
  logic             g_en;
  logic             last;
  logic             lock_hold;

  rtc_rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef RTC_BUS_LOCK_EN
  assign lock_hold = req_lock[idx_q] & req[idx_q];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_hold   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    oe_d    = oe_q;
    lock_d  = lock_q;
    wdata_d = wdata_q;
    ad_d    = ad_q;
    rdata_d = rdata_q;
    last    = (cnt_q == '0);
    g_idx   = lock_q ? idx_q : pick_idx;
    g_en    = lock_q | pick_any;
    unique case (state_q)
      IDLE: begin
        if (g_en) begin
          state_d = ADDR_ACT;
          cnt_d   = P_LAST;
          idx_d   = g_idx;
          gnt_d   = lock_q ? (N_REQ'(1) << idx_q) : pick_oh;
          ptr_d   = (int'(g_idx) == N_REQ - 1) ? '0 : g_idx + 1'b1;
          wr_d    = req_wr[g_idx];
          ad_d    = req_addr[RTC_ADDR_W*g_idx +: RTC_ADDR_W];
          wdata_d = req_wdata[RTC_DATA_W*g_idx +: RTC_DATA_W];
          oe_d    = 1'b1;
          lock_d  = 1'b0;
        end
      end
      ADDR_ACT: begin
        if (last) begin
          state_d = ADDR_GAP;
          cnt_d   = G_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ADDR_GAP: begin
        if (last) begin
          state_d = DATA_ACT;
          cnt_d   = P_LAST;
          oe_d    = wr_q;
          if (wr_q) ad_d = wdata_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA_ACT: begin
        if (last) begin
          state_d = DATA_GAP;
          cnt_d   = G_LAST;
          oe_d    = 1'b0;
          if (!wr_q) rdata_d = ad_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA_GAP: begin
        if (last) begin
          state_d = IDLE;
          lock_d  = lock_hold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // done and grant release land together on the final gap cycle
    done_d = (state_d == DATA_GAP && cnt_d == '0) ? gnt_q : '0;
    if (|done_d) gnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      lock_q  <= 1'b0;
      wdata_q <= '0;
      ad_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      lock_q  <= lock_d;
      wdata_q <= wdata_d;
      ad_q    <= ad_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign ad_out = ad_q;
  assign ad_oe  = oe_q;
  assign CS     = !(state_q == ADDR_ACT || state_q == DATA_ACT);
  assign WR     = !(state_q == ADDR_ACT || (state_q == DATA_ACT && wr_q));
  assign RD     = !(state_q == DATA_ACT && !wr_q);
  assign AD_o   = (state_q == DATA_ACT || state_q == DATA_GAP);

endmodule
